// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver.
// Recovers start, FRAME_WIDTH data bits (LSB first), optional parity and stop
// from RX_IN using a 3-sample majority vote around the middle of each bit.
// Optional macro UART_RX_SYNC_EN: adds a 2-flop synchronizer on RX_IN
// (reset value 1), which shifts all timing by +2 cycles.
module uart_rx_core #(
    parameter int unsigned FRAME_WIDTH    = 8,
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      par_en,
    input  logic                      PAR_TYP,
    output logic [FRAME_WIDTH-1:0]    P_DATA,
    output logic                      data_valid,
    output logic                      par_err,
    output logic                      stp_err,
    output logic                      busy
);

    localparam int unsigned   BCW      = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic                      w_rx;
    logic [PRESCALE_WIDTH-1:0] r_edge_cnt;
    logic [BCW-1:0]            r_bit_cnt;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic                      r_par_en;
    logic                      r_par_typ;
    logic                      r_s0;
    logic                      r_s1;
    logic [FRAME_WIDTH-1:0]    r_shift;
    logic                      r_par_bad;
    logic                      r_stop_ok;
    logic [FRAME_WIDTH-1:0]    r_p_data;
    logic                      r_data_valid;
    logic                      r_par_err;
    logic                      r_stp_err;

    logic [PRESCALE_WIDTH-1:0] w_half;
    logic [PRESCALE_WIDTH-1:0] w_samp0;
    logic [PRESCALE_WIDTH-1:0] w_samp1;
    logic [PRESCALE_WIDTH-1:0] w_samp2;
    logic [PRESCALE_WIDTH-1:0] w_last;
    logic                      w_decide;
    logic                      w_bit_end;
    logic                      w_maj;

`ifdef UART_RX_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Two-stage synchronizer for the asynchronous serial line.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= RX_IN;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx = r_sync2;
`else
    assign w_rx = RX_IN;
`endif

    assign w_half    = r_prescale >> 1;
    assign w_samp0   = w_half - PRESCALE_WIDTH'(1);
    assign w_samp1   = w_half;
    assign w_samp2   = w_half + PRESCALE_WIDTH'(1);
    assign w_last    = r_prescale - PRESCALE_WIDTH'(1);
    assign w_decide  = (r_edge_cnt == w_samp2);
    assign w_bit_end = (r_edge_cnt == w_last);
    // Third sample is taken live at the decision point.
    assign w_maj     = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (!w_rx) begin
                    w_next = START;
                end
            end
            START: begin
                if (w_decide && w_maj) begin
                    w_next = IDLE;
                end else if (w_bit_end) begin
                    w_next = DATA;
                end
            end
            DATA: begin
                if (w_bit_end && (r_bit_cnt == LAST_BIT)) begin
                    w_next = r_par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_next = STOP;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Bit timing, sampling, data capture and result pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_edge_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_prescale   <= '0;
            r_par_en     <= 1'b0;
            r_par_typ    <= 1'b0;
            r_s0         <= 1'b0;
            r_s1         <= 1'b0;
            r_shift      <= '0;
            r_par_bad    <= 1'b0;
            r_stop_ok    <= 1'b0;
            r_p_data     <= '0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;

            if (r_state == IDLE) begin
                r_edge_cnt <= '0;
                r_bit_cnt  <= '0;
                if (w_next == START) begin
                    // The detection cycle is edge 0 of the start bit, so the
                    // first START cycle is already edge 1.
                    r_edge_cnt <= PRESCALE_WIDTH'(1);
                    r_prescale <= prescale;
                    r_par_en   <= par_en;
                    r_par_typ  <= PAR_TYP;
                    r_par_bad  <= 1'b0;
                end
            end else begin
                if (w_bit_end || (w_next == IDLE)) begin
                    r_edge_cnt <= '0;
                end else begin
                    r_edge_cnt <= r_edge_cnt + PRESCALE_WIDTH'(1);
                end
                if (r_edge_cnt == w_samp0) begin
                    r_s0 <= w_rx;
                end
                if (r_edge_cnt == w_samp1) begin
                    r_s1 <= w_rx;
                end
            end

            case (r_state)
                DATA: begin
                    if (w_decide) begin
                        r_shift <= {w_maj, r_shift[FRAME_WIDTH-1:1]};
                    end
                    if (w_bit_end) begin
                        r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + BCW'(1);
                    end
                end
                PARITY: begin
                    if (w_decide) begin
                        r_par_bad <= (w_maj != ((^r_shift) ^ r_par_typ));
                    end
                end
                STOP: begin
                    if (w_decide) begin
                        r_stop_ok <= w_maj;
                    end
                    if (w_bit_end) begin
                        r_par_err <= r_par_bad;
                        r_stp_err <= ~r_stop_ok;
                        if (r_stop_ok && !r_par_bad) begin
                            r_data_valid <= 1'b1;
                            r_p_data     <= r_shift;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign P_DATA     = r_p_data;
    assign data_valid = r_data_valid;
    assign par_err    = r_par_err;
    assign stp_err    = r_stp_err;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed vector table, hand-written
// glitch / back-to-back / mid-frame reset sequences, then random frames
// checked against a frame-level reference model.
module tb_uart_rx_core;

    localparam int unsigned FW = 8;
    localparam int unsigned PW = 6;
`ifdef UART_RX_SYNC_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 0;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic          RX_IN;
    logic [PW-1:0] prescale;
    logic          par_en;
    logic          PAR_TYP;
    logic [FW-1:0] P_DATA;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;
    logic          busy;

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;

    typedef struct {
        int unsigned   cyc;
        logic          dv;
        logic          pe;
        logic          se;
        logic [FW-1:0] pd;
    } ev_t;

    typedef struct {
        int unsigned   p;
        logic          pen;
        logic          ptyp;
        logic [FW-1:0] data;
        logic          pbit;
        logic          stopb;
        int unsigned   lat;
        logic          dv;
        logic          pe;
        logic          se;
        logic [FW-1:0] pd;
    } vec_t;

    ev_t  evq[$];
    vec_t vecs[10];

    uart_rx_core #(
        .FRAME_WIDTH   (FW),
        .PRESCALE_WIDTH(PW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_IN     (RX_IN),
        .prescale  (prescale),
        .par_en    (par_en),
        .PAR_TYP   (PAR_TYP),
        .P_DATA    (P_DATA),
        .data_valid(data_valid),
        .par_err   (par_err),
        .stp_err   (stp_err),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Record every result pulse with the cycle it was seen in.
    always @(negedge CLK) begin
        if (data_valid || par_err || stp_err) begin
            evq.push_back('{cyc, data_valid, par_err, stp_err, P_DATA});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge CLK); #1;
            RX_IN = 1'b1;
        end
    endtask

    // Drive one frame; config is presented with the start bit and scrambled
    // from the first data bit on, so only the captured values may matter.
    task automatic send_frame(input int unsigned p, input logic pen, input logic ptyp,
                              input logic [FW-1:0] data, input logic pbit, input logic stopb,
                              input int unsigned gap, output int unsigned t0);
        logic bits[$];
        bits.push_back(1'b0);
        for (int unsigned i = 0; i < FW; i++) bits.push_back(data[i]);
        if (pen) bits.push_back(pbit);
        bits.push_back(stopb);
        idle(gap);
        t0 = 0;
        for (int b = 0; b < bits.size(); b++) begin
            for (int unsigned c = 0; c < p; c++) begin
                @(posedge CLK); #1;
                RX_IN = bits[b];
                if (b == 0 && c == 0) begin
                    t0       = cyc;
                    prescale = PW'(p);
                    par_en   = pen;
                    PAR_TYP  = ptyp;
                end
                if (b == 1 && c == 0) begin
                    prescale = PW'($urandom_range(0, 63));
                    par_en   = 1'($urandom_range(0, 1));
                    PAR_TYP  = 1'($urandom_range(0, 1));
                end
            end
        end
    endtask

    task automatic check_result(input string tag, input int unsigned t0, input int unsigned lat,
                                input logic dv, input logic pe, input logic se,
                                input logic [FW-1:0] pd);
        ev_t ev;
        idle(8);
        @(negedge CLK); #1;
        chk({tag, ".pulses"}, 32'(evq.size()), 32'd1);
        if (evq.size() > 0) begin
            ev = evq[0];
            chk({tag, ".cycle"}, ev.cyc, t0 + lat + LAT);
            chk({tag, ".data_valid"}, 32'(ev.dv), 32'(dv));
            chk({tag, ".par_err"}, 32'(ev.pe), 32'(pe));
            chk({tag, ".stp_err"}, 32'(ev.se), 32'(se));
        end
        chk({tag, ".P_DATA"}, 32'(P_DATA), 32'(pd));
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        evq.delete();
    endtask

    initial begin
        int unsigned   t0;
        int unsigned   t1;
        int unsigned   p;
        logic          pen;
        logic          ptyp;
        logic          flip;
        logic          stop0;
        logic [FW-1:0] data;
        logic [FW-1:0] model_pd;
        logic          pbit;
        logic          exp_dv;
        logic          exp_pe;
        logic          exp_se;

        //         p   pen ptyp data   pbit stop lat  dv pe se pd
        vecs[0] = '{8,  0,  0,  8'hA5, 0,   1,   80,  1, 0, 0, 8'hA5};
        vecs[1] = '{16, 1,  0,  8'h3C, 0,   1,   176, 1, 0, 0, 8'h3C};
        vecs[2] = '{16, 1,  0,  8'h3C, 1,   1,   176, 0, 1, 0, 8'h3C};
        vecs[3] = '{8,  1,  1,  8'h01, 0,   0,   88,  0, 0, 1, 8'h3C};
        vecs[4] = '{8,  1,  1,  8'h01, 1,   0,   88,  0, 1, 1, 8'h3C};
        vecs[5] = '{32, 0,  1,  8'hC3, 0,   1,   320, 1, 0, 0, 8'hC3};
        vecs[6] = '{8,  1,  1,  8'h80, 0,   1,   88,  1, 0, 0, 8'h80};
        vecs[7] = '{16, 1,  1,  8'h00, 1,   1,   176, 1, 0, 0, 8'h00};
        vecs[8] = '{16, 1,  0,  8'hFF, 0,   1,   176, 1, 0, 0, 8'hFF};
        vecs[9] = '{8,  0,  0,  8'h5A, 0,   0,   80,  0, 0, 1, 8'hFF};

        RST      = 1'b1;
        RX_IN    = 1'b1;
        prescale = PW'(8);
        par_en   = 1'b0;
        PAR_TYP  = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset.P_DATA", 32'(P_DATA), 32'd0);
        chk("reset.data_valid", 32'(data_valid), 32'd0);
        chk("reset.par_err", 32'(par_err), 32'd0);
        chk("reset.stp_err", 32'(stp_err), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        idle(4);
        evq.delete();

        for (int i = 0; i < 10; i++) begin
            send_frame(vecs[i].p, vecs[i].pen, vecs[i].ptyp, vecs[i].data,
                       vecs[i].pbit, vecs[i].stopb, 3, t0);
            check_result($sformatf("vec%0d", i), t0, vecs[i].lat,
                         vecs[i].dv, vecs[i].pe, vecs[i].se, vecs[i].pd);
        end

        // Start glitch: line low for two cycles only.
        prescale = PW'(8);
        par_en   = 1'b0;
        PAR_TYP  = 1'b0;
        idle(3);
        for (int unsigned i = 0; i < 12; i++) begin
            @(posedge CLK); #1;
            RX_IN = (i < 2) ? 1'b0 : 1'b1;
            if (i == 3) begin
                @(negedge CLK);
                chk("glitch.busy_high", 32'(busy), 32'd1);
            end
        end
        @(negedge CLK);
        chk("glitch.busy_low", 32'(busy), 32'd0);
        chk("glitch.no_pulse", 32'(evq.size()), 32'd0);
        evq.delete();
        send_frame(8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 2, t0);
        check_result("after_glitch", t0, 80, 1'b1, 1'b0, 1'b0, 8'h5A);

        // Back-to-back frames with no idle gap.
        send_frame(32, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 3, t0);
        send_frame(32, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0, t1);
        idle(8);
        @(negedge CLK); #1;
        chk("b2b.pulses", 32'(evq.size()), 32'd2);
        if (evq.size() == 2) begin
            chk("b2b.cycle0", evq[0].cyc, t0 + 320 + LAT);
            chk("b2b.cycle1", evq[1].cyc, t0 + 640 + LAT);
            chk("b2b.dv0", 32'(evq[0].dv), 32'd1);
            chk("b2b.dv1", 32'(evq[1].dv), 32'd1);
            chk("b2b.pd0", 32'(evq[0].pd), 32'hFF);
            chk("b2b.pd1", 32'(evq[1].pd), 32'h00);
        end
        evq.delete();

        // Reset during the data bits of a 0x77 frame.
        idle(3);
        @(posedge CLK); #1;
        prescale = PW'(8);
        par_en   = 1'b0;
        PAR_TYP  = 1'b0;
        RX_IN    = 1'b0;
        repeat (7) begin @(posedge CLK); #1; end
        RX_IN = 1'b1;
        repeat (20) begin @(posedge CLK); #1; end
        @(negedge CLK);
        chk("rst_mid.busy_before", 32'(busy), 32'd1);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_mid.P_DATA", 32'(P_DATA), 32'd0);
        chk("rst_mid.data_valid", 32'(data_valid), 32'd0);
        chk("rst_mid.par_err", 32'(par_err), 32'd0);
        chk("rst_mid.stp_err", 32'(stp_err), 32'd0);
        chk("rst_mid.busy", 32'(busy), 32'd0);
        idle(100);
        @(negedge CLK);
        chk("rst_mid.no_pulse", 32'(evq.size()), 32'd0);
        evq.delete();
        send_frame(8, 1'b0, 1'b0, 8'h12, 1'b0, 1'b1, 2, t0);
        check_result("after_rst", t0, 80, 1'b1, 1'b0, 1'b0, 8'h12);

        // Random frames against the frame-level model.
        model_pd = 8'h12;
        for (int unsigned n = 0; n < 24; n++) begin
            p     = 8 << $urandom_range(0, 2);
            pen   = 1'($urandom_range(0, 1));
            ptyp  = 1'($urandom_range(0, 1));
            data  = FW'($urandom);
            flip  = ($urandom_range(0, 5) == 0);
            stop0 = ($urandom_range(0, 5) == 0);
            pbit   = (^data) ^ ptyp ^ flip;
            exp_pe = pen && flip;
            exp_se = stop0;
            exp_dv = !exp_pe && !exp_se;
            if (exp_dv) model_pd = data;
            send_frame(p, pen, ptyp, data, pbit, ~stop0, $urandom_range(0, 3), t0);
            check_result($sformatf("rnd%0d", n), t0, (2 + FW + 32'(pen)) * p,
                         exp_dv, exp_pe, exp_se, model_pd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
UART receiver that sits directly downstream of the UART transmitter. It consumes the serial line the transmitter drives and rebuilds the parallel frame. It oversamples RX_IN at a runtime-selectable prescale and recovers start, data (LSB first), optional parity and stop bits. It presents a one-cycle data_valid pulse with P_DATA, or flags a parity or stop (framing) error. Frame format matches the transmitter: start=0, FRAME_WIDTH data bits, optional parity (PAR_TYP 0=even, 1=odd), stop=1.

Parameters:
FRAME_WIDTH, 8, data bits per frame
PRESCALE_WIDTH, 6, width of the prescale input

Ports:
CLK  input  1  system clock, all logic rising-edge
RST  input  1  synchronous, active-high reset
RX_IN  input  1  serial line, idle high
prescale  input  PRESCALE_WIDTH  clocks per bit; legal values 8, 16, 32
par_en  input  1  1 = parity bit present
PAR_TYP  input  1  0 = even, 1 = odd
P_DATA  output  FRAME_WIDTH  received data, LSB first on the line
data_valid  output  1  one-cycle pulse, P_DATA valid
par_err  output  1  one-cycle pulse, parity mismatch
stp_err  output  1  one-cycle pulse, stop bit sampled 0
busy  output  1  high while not IDLE

Behaviour:
- Reset (RST=1 at a CLK edge): state=IDLE, edge_cnt=0, bit_cnt=0, P_DATA=0, data_valid=0, par_err=0, stp_err=0, busy=0.
- RST mid-frame aborts the frame with no pulses.
- Counters:
  - edge_cnt runs 0..prescale-1 within each bit and wraps to 0 at the bit boundary.
  - bit_cnt counts data bits 0..FRAME_WIDTH-1.
- Sampling:
  - RX_IN is sampled at edge_cnt = P/2-1, P/2 and P/2+1, where P = prescale.
  - The bit value is the majority of the 3 samples.
  - The bit is decided at edge_cnt = P/2+1.
- Configuration: prescale, par_en and PAR_TYP are captured when leaving IDLE and held for the frame. Changes mid-frame have no effect.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if RX_IN=0 at cycle T, go to START with edge_cnt=0 at T. busy rises at T+1.
  - START: if the majority at the sample point is 1 (glitch), return to IDLE immediately with no pulses. Otherwise, at edge_cnt=P-1, go to DATA.
  - DATA: at each sample point, shift the bit into the shift register at the MSB side (LSB received first). At edge_cnt=P-1 with bit_cnt=FRAME_WIDTH-1, go to PARITY if par_en, else STOP.
  - PARITY: expected parity = XOR of the data bits, inverted if PAR_TYP=1. Record a mismatch. At edge_cnt=P-1, go to STOP.
  - STOP: sample the stop bit. At edge_cnt=P-1, go to IDLE and issue the result pulses on the next cycle.
- Result, registered and one cycle high at T+N*P, where N = 10 (no parity) or 11 (parity) for FRAME_WIDTH=8:
  - stop=1 and parity OK or disabled: data_valid=1, P_DATA updated.
  - parity mismatch: par_err=1, data_valid=0.
  - stop=0: stp_err=1, data_valid=0.
  - Both parity and stop errors: par_err and stp_err both pulse.
- P_DATA updates only on data_valid and holds its last good value otherwise.
- Back-to-back frames: IDLE re-arms in the cycle after STOP ends. A start bit already low at that point is detected with ≤1 cycle skew, which is absorbed by the mid-bit sampling.
- No backpressure; the consumer must take P_DATA on the data_valid pulse.
- Illegal prescale values: behaviour undefined, not checked.

Optional Feature:
- Macro: UART_RX_SYNC_EN.
- Defined: RX_IN passes through a 2-flop synchronizer (reset value 1) before the FSM. All timing above shifts +2 cycles.
- Undefined: RX_IN is used directly, and the input is assumed synchronous to CLK.

Test Plan:
1. prescale=8, par_en=0, send 0xA5 (line: 0,1,0,1,0,0,1,0,1,1) -> data_valid pulse at T+80, P_DATA=0xA5, no error pulses.
2. prescale=16, par_en=1, PAR_TYP=0, send 0x3C with parity 0 -> data_valid at T+176, P_DATA=0x3C. Same frame with parity bit 1 -> par_err pulse, data_valid=0, P_DATA still 0x3C.
3. prescale=8, par_en=1, PAR_TYP=1, send 0x01 with stop bit driven 0 -> stp_err pulse at T+88, data_valid=0.
4. prescale=8, RX_IN low for 2 cycles then high -> FSM returns to IDLE, busy drops, no pulses. A following valid 0x5A frame -> P_DATA=0x5A.
5. prescale=32, two back-to-back frames 0xFF then 0x00 with no idle gap -> two data_valid pulses 320 cycles apart, P_DATA=0xFF then 0x00.
6. Assert RST during DATA of a 0x77 frame -> all outputs 0 and state IDLE the next cycle, no pulses. The next frame 0x12 is received correctly.
